// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/valid handshake and issues one
// instruction per visit to ISSUE. Optional misaligned-target trap: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
`endif
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_branch,
    input  logic        i_cnt1,
    input  logic        i_cnt2,
    input  logic        i_zero,
    input  logic [31:0] i_imm_ext,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_valid,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_instr,
    output logic [6:0]  o_opcode,
    output logic        o_instr_valid,
    output logic        o_misalign_err
);

    typedef enum logic {StFetch, StIssue} state_e;

    state_e      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_imem_req;
    logic [31:0] w_next_pc;

    // jalr beats jal, jal beats a taken branch, otherwise fall through
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (i_cnt1 && i_cnt2) begin
            w_next_pc = i_alu_result & 32'hFFFF_FFFE;
        end else if (i_cnt1 || (i_branch && i_zero)) begin
            w_next_pc = r_pc + i_imm_ext;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misalign;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StFetch;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misalign    <= 1'b0;
`endif
        end else begin
            case (r_state)
                StFetch: begin
                    if (r_imem_req && i_imem_valid) begin
                        r_instr       <= i_imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= StIssue;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                StIssue: begin
                    if (!i_stall) begin
                        r_instr_valid <= 1'b0;
                        // request the next word immediately to sustain 3-cycle throughput
                        r_imem_req    <= 1'b1;
                        r_state       <= StFetch;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (w_next_pc[1:0] != 2'b00) begin
                            r_pc       <= TRAP_VECTOR;
                            r_misalign <= 1'b1;
                        end else begin
                            r_pc <= w_next_pc;
                        end
`else
                        r_pc <= w_next_pc;
`endif
                    end
                end
                default: r_state <= StFetch;
            endcase
        end
    end

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_pc;
    assign o_pc          = r_pc;
    assign o_pc_plus4    = r_pc + 32'd4;
    assign o_instr       = r_instr;
    assign o_opcode      = r_instr[6:0];
    assign o_instr_valid = r_instr_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign o_misalign_err = r_misalign;
`else
    assign o_misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized instruction streams
// checked against a PC-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_stall = 1'b0;
    logic        i_branch = 1'b0;
    logic        i_cnt1 = 1'b0;
    logic        i_cnt2 = 1'b0;
    logic        i_zero = 1'b0;
    logic [31:0] i_imm_ext = '0;
    logic [31:0] i_alu_result = '0;
    logic [31:0] i_imem_rdata = '0;
    logic        i_imem_valid = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic [31:0] o_instr;
    logic [6:0]  o_opcode;
    logic        o_instr_valid;
    logic        o_misalign_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_pc;
    logic        m_err;

    localparam logic [31:0] ResetPc  = 32'h0000_0000;
    localparam logic [31:0] NopInstr = 32'h0000_0013;
    localparam logic [31:0] TrapVec  = 32'h0000_0100;

    always #5 clk = ~clk;

    fetch_unit dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_stall        (i_stall),
        .i_branch       (i_branch),
        .i_cnt1         (i_cnt1),
        .i_cnt2         (i_cnt2),
        .i_zero         (i_zero),
        .i_imm_ext      (i_imm_ext),
        .i_alu_result   (i_alu_result),
        .i_imem_rdata   (i_imem_rdata),
        .i_imem_valid   (i_imem_valid),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .o_pc           (o_pc),
        .o_pc_plus4     (o_pc_plus4),
        .o_instr        (o_instr),
        .o_opcode       (o_opcode),
        .o_instr_valid  (o_instr_valid),
        .o_misalign_err (o_misalign_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: jump-register target, else pc-relative jump/taken branch, else sequential.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic br, input logic c1,
                                             input logic c2, input logic z,
                                             input logic [31:0] imm, input logic [31:0] alu);
        if (c1 && c2) return {alu[31:1], 1'b0};
        if (c1) return pc + imm;
        if (br && z) return pc + imm;
        return pc + 32'd4;
    endfunction

    task automatic model_reset();
        m_pc  = ResetPc;
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_imem_valid = 1'b0;
        i_stall = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        model_reset();
    endtask

    task automatic randomize_dont_care();
        i_branch     = 1'($urandom);
        i_cnt1       = 1'($urandom);
        i_cnt2       = 1'($urandom);
        i_zero       = 1'($urandom);
        i_imm_ext    = $urandom;
        i_alu_result = $urandom;
    endtask

    // Fetch one instruction with the given latency, stall it, then retire it with the given
    // control inputs.
    task automatic run_instr(input logic [31:0] instr, input int lat, input int stalls,
                             input logic br, input logic c1, input logic c2, input logic z,
                             input logic [31:0] imm, input logic [31:0] alu);
        int waited;
        logic [31:0] npc;
        waited = 0;
        while (o_imem_req !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        checks++;
        if (o_imem_req !== 1'b1) begin
            $display("FAIL req_rise: req=%b required 1", o_imem_req);
            errors++;
        end
        for (int i = 0; i < lat; i++) begin
            randomize_dont_care();
            checks++;
            if (o_imem_addr !== m_pc || o_imem_req !== 1'b1 || o_instr_valid !== 1'b0) begin
                $display("FAIL fetch_hold: addr=%h req=%b iv=%b required addr=%h req=1 iv=0",
                         o_imem_addr, o_imem_req, o_instr_valid, m_pc);
                errors++;
            end
            if (i == lat - 1) begin
                i_imem_valid = 1'b1;
                i_imem_rdata = instr;
            end
            tick();
        end
        i_imem_valid = 1'b0;
        i_imem_rdata = $urandom;
        checks++;
        if (o_instr_valid !== 1'b1 || o_instr !== instr || o_opcode !== instr[6:0]
            || o_pc !== m_pc || o_pc_plus4 !== m_pc + 32'd4 || o_imem_req !== 1'b0) begin
            $display("FAIL issue: iv=%b instr=%h op=%b pc=%h pc4=%h req=%b required iv=1 instr=%h op=%b pc=%h pc4=%h req=0",
                     o_instr_valid, o_instr, o_opcode, o_pc, o_pc_plus4, o_imem_req,
                     instr, instr[6:0], m_pc, m_pc + 32'd4);
            errors++;
        end
        for (int s = 0; s < stalls; s++) begin
            // valid data arriving outside FETCH must be ignored
            i_stall = 1'b1;
            i_imem_valid = 1'b1;
            i_imem_rdata = ~instr;
            randomize_dont_care();
            tick();
            checks++;
            if (o_instr_valid !== 1'b1 || o_instr !== instr || o_pc !== m_pc
                || o_imem_addr !== m_pc) begin
                $display("FAIL stall_hold: iv=%b instr=%h pc=%h required iv=1 instr=%h pc=%h",
                         o_instr_valid, o_instr, o_pc, instr, m_pc);
                errors++;
            end
        end
        i_stall = 1'b0;
        i_imem_valid = 1'b0;
        i_branch = br;
        i_cnt1 = c1;
        i_cnt2 = c2;
        i_zero = z;
        i_imm_ext = imm;
        i_alu_result = alu;
        npc = ref_next(m_pc, br, c1, c2, z, imm, alu);
`ifdef FETCH_MISALIGN_TRAP_EN
        if (npc % 4 != 0) begin
            npc = TrapVec;
            m_err = 1'b1;
        end
`endif
        m_pc = npc;
        tick();
        checks++;
        if (o_pc !== m_pc || o_instr_valid !== 1'b0 || o_imem_req !== 1'b1
            || o_misalign_err !== m_err) begin
            $display("FAIL retire: pc=%h iv=%b req=%b merr=%b required pc=%h iv=0 req=1 merr=%b",
                     o_pc, o_instr_valid, o_imem_req, o_misalign_err, m_pc, m_err);
            errors++;
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick();
        tick();
        checks++;
        if (o_pc !== ResetPc || o_instr !== NopInstr || o_instr_valid !== 1'b0
            || o_imem_req !== 1'b0 || o_misalign_err !== 1'b0 || o_opcode !== 7'h13
            || o_pc_plus4 !== 32'h4) begin
            $display("FAIL reset: pc=%h instr=%h iv=%b req=%b merr=%b op=%h pc4=%h",
                     o_pc, o_instr, o_instr_valid, o_imem_req, o_misalign_err, o_opcode,
                     o_pc_plus4);
            errors++;
        end
        i_reset = 1'b0;
        model_reset();
        tick();
        checks++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== ResetPc) begin
            $display("FAIL reset_exit_req: req=%b addr=%h required 1 / %h",
                     o_imem_req, o_imem_addr, ResetPc);
            errors++;
        end
    endtask

    task automatic test_basic_fetch();
        run_instr(32'h0050_0093, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (o_pc !== 32'h4) begin
            $display("FAIL basic_pc: pc=%h required 00000004", o_pc);
            errors++;
        end
    endtask

    task automatic test_branch();
        run_instr(32'h0000_0013, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        run_instr(32'hFE00_0CE3, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0);
        checks++;
        if (o_pc !== 32'h0) begin
            $display("FAIL beq_taken: pc=%h required 00000000", o_pc);
            errors++;
        end
        run_instr(32'h0000_0013, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        run_instr(32'h0000_0013, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        run_instr(32'hFE00_0CE3, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
        checks++;
        if (o_pc !== 32'hC) begin
            $display("FAIL beq_not_taken: pc=%h required 0000000c", o_pc);
            errors++;
        end
    endtask

    task automatic test_jumps();
        run_instr(32'h0000_006F, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20 - m_pc, 32'h0);
        run_instr(32'h0000_80E7, 1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h45);
        checks++;
        if (o_pc !== 32'h44) begin
            $display("FAIL jalr: pc=%h required 00000044", o_pc);
            errors++;
        end
        run_instr(32'h0000_006F, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFDC, 32'h0);
        run_instr(32'h0100_006F, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h99);
        checks++;
        if (o_pc !== 32'h30) begin
            $display("FAIL jal_over_branch: pc=%h required 00000030", o_pc);
            errors++;
        end
    endtask

    task automatic test_stall_latency();
        run_instr(32'h0010_0113, 4, 3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_wrap();
        run_instr(32'h0000_80E7, 2, 0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFD);
        run_instr(32'h0000_0013, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (o_pc !== 32'h0) begin
            $display("FAIL wrap: pc=%h required 00000000", o_pc);
            errors++;
        end
    endtask

    task automatic test_reset_mid_fetch();
        run_instr(32'h0000_0013, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        i_reset = 1'b1;
        i_imem_valid = 1'b1;
        i_imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        checks++;
        if (o_pc !== ResetPc || o_instr !== NopInstr || o_instr_valid !== 1'b0
            || o_imem_req !== 1'b0) begin
            $display("FAIL reset_mid_fetch: pc=%h instr=%h iv=%b req=%b",
                     o_pc, o_instr, o_instr_valid, o_imem_req);
            errors++;
        end
        i_reset = 1'b0;
        i_imem_valid = 1'b0;
        model_reset();
        tick();
        checks++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== ResetPc || o_instr_valid !== 1'b0) begin
            $display("FAIL refetch: req=%b addr=%h iv=%b required 1 / %h / 0",
                     o_imem_req, o_imem_addr, o_instr_valid, ResetPc);
            errors++;
        end
        run_instr(32'h0020_0193, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_in_issue();
        i_imem_valid = 1'b1;
        i_imem_rdata = 32'h1234_5678;
        tick();
        i_imem_valid = 1'b0;
        i_stall = 1'b0;
        i_reset = 1'b1;
        tick();
        checks++;
        if (o_instr_valid !== 1'b0 || o_pc !== ResetPc || o_instr !== NopInstr) begin
            $display("FAIL reset_in_issue: iv=%b pc=%h instr=%h", o_instr_valid, o_pc, o_instr);
            errors++;
        end
        i_reset = 1'b0;
        model_reset();
    endtask

    task automatic test_misalign();
        do_reset();
        run_instr(32'h0060_006F, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h6, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++;
        if (o_pc !== 32'h100 || o_misalign_err !== 1'b1) begin
            $display("FAIL misalign_trap: pc=%h merr=%b required 00000100 / 1",
                     o_pc, o_misalign_err);
            errors++;
        end
`else
        checks++;
        if (o_pc !== 32'h6 || o_misalign_err !== 1'b0) begin
            $display("FAIL misalign_pass: pc=%h merr=%b required 00000006 / 0",
                     o_pc, o_misalign_err);
            errors++;
        end
`endif
        run_instr(32'h0000_0013, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] imm;
        for (int n = 0; n < 40; n++) begin
            imm = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            run_instr($urandom, $urandom_range(1, 4), $urandom_range(0, 2),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), imm, $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_basic_fetch();
        test_branch();
        test_jumps();
        test_stall_latency();
        test_wrap();
        test_reset_mid_fetch();
        test_reset_in_issue();
        test_misalign();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the control unit.
- Holds the PC and issues word reads to instruction memory over a req/valid handshake.
- Latches the returned instruction and presents it, with Opcode = Instr[6:0], to decode/control for exactly one issue cycle.
- On that issue cycle, computes next PC from the control unit's Branch/cnt1/cnt2 outputs, the ALU Zero flag, the immediate and the ALU result.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, Instr value after reset (addi x0,x0,0).
- TRAP_VECTOR, 32'h0000_0100, redirect target for misaligned jumps (optional feature only).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Stall  input  1  holds the ISSUE state (PC and Instr frozen).
- Branch  input  1  from control unit.
- cnt1  input  1  from control unit: jump.
- cnt2  input  1  from control unit: register-indirect jump (jalr).
- Zero  input  1  ALU zero flag.
- ImmExt  input  32  sign-extended immediate.
- ALUResult  input  32  ALU result (jalr target).
- IMemRdata  input  32  instruction memory read data.
- IMemValid  input  1  read data valid.
- IMemReq  output  1  read request.
- IMemAddr  output  32  read address (equals PC).
- PC  output  32  current PC.
- PCPlus4  output  32  PC+4, for the jal/jalr link value.
- Instr  output  32  latched instruction.
- Opcode  output  7  Instr[6:0].
- InstrValid  output  1  Instr is being issued this cycle.
- MisalignErr  output  1  optional feature only; otherwise tied to 0.

Behaviour:
- Reset (synchronous, active-high): state=FETCH, PC=RESET_PC, Instr=NOP_INSTR, InstrValid=0, IMemReq=0, MisalignErr=0. Reset wins over every other input in the same cycle, including mid-fetch and during ISSUE.
- States: FETCH, ISSUE. All outputs are registered except Opcode, PCPlus4 and IMemAddr, which are combinational from registers.
- FETCH:
  - IMemReq=1 from the cycle after reset exit, held until IMemValid is sampled high.
  - IMemAddr=PC, stable while IMemReq=1.
  - On an edge with IMemValid=1: Instr<=IMemRdata, InstrValid<=1, IMemReq<=0, go to ISSUE.
  - Memory latency is arbitrary, ≥1 cycle after IMemReq rises.
- ISSUE:
  - InstrValid=1.
  - If Stall=1: hold the state; PC and Instr unchanged.
  - If Stall=0: PC<=NextPC, InstrValid<=0, go to FETCH.
  - Minimum throughput: one instruction per 3 cycles with 1-cycle memory (req, valid, issue).
- NextPC priority, evaluated only in ISSUE:
  - cnt1&cnt2 -> (ALUResult & 32'hFFFF_FFFE).
  - else cnt1 -> PC+ImmExt.
  - else Branch&Zero -> PC+ImmExt.
  - else PC+4.
- Arithmetic: 32-bit, modulo 2^32. PC=32'hFFFF_FFFC plus 4 wraps to 0 with no flag.
- IMemValid sampled outside FETCH is ignored. IMemRdata is ignored unless IMemValid=1 in FETCH.
- Branch/cnt/Zero/ImmExt/ALUResult are don't-care outside ISSUE.
- Without the optional feature, a NextPC with bit1 set is loaded unchanged.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - If the selected NextPC has bits[1:0]!=0 on an ISSUE exit, PC<=TRAP_VECTOR and MisalignErr<=1.
  - MisalignErr is sticky until reset.
- Undefined: no check is made and MisalignErr is constant 0.

Test Plan:
- Reset then 1-cycle memory returning 32'h00500093: IMemReq=1 at addr 0; next edge Instr=32'h00500093, Opcode=7'b0010011, InstrValid=1 for one cycle; PC becomes 4.
- beq at PC=8 with ImmExt=32'hFFFF_FFF8: Branch=1, Zero=1 -> PC=0; same with Zero=0 -> PC=12.
- jalr at PC=0x20, cnt1=cnt2=1, ALUResult=0x45 -> PC=0x44, PCPlus4=0x24 during ISSUE. Both Branch=1 and cnt1=1 with ImmExt=0x10 -> PC=0x30 (jal priority over branch).
- 4-cycle memory latency with Stall=1 held 3 cycles in ISSUE: IMemAddr stable throughout; Instr/PC frozen; InstrValid stays 1; advances on the first Stall=0 edge.
- Reset asserted while IMemReq=1, with IMemValid arriving during reset: PC=RESET_PC, Instr=NOP_INSTR, no ISSUE; the fetch restarts at RESET_PC.
- FETCH_MISALIGN_TRAP_EN defined, jal at PC=0 with ImmExt=0x6: PC=0x100, MisalignErr=1, held after the next fetch. Undefined: PC=0x6, MisalignErr=0.
